// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the common-bus transfer controller.
//   - state_e : sequencer states (IDLE, SEL, XFER, ACK)
//   - OP_*    : per-requester operation codes
//   - DEF_*   : default widths for requesters, registers and register index
//   - idx_w() : index width for a one-hot vector of n bits (at least 1)
package bus_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_N_REG = 8;
  localparam int DEF_SW    = 3;

  localparam logic [1:0] OP_XFER = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_XFER = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// bus_xfer_ctrl_if: requester/bus-register side of the transfer controller.
//   req/op/src/dst : per-requester request level and packed fields
//   gnt/done/err/busy : handshake back to the requesters
//   bus_sel : common-bus source mux select
//   reg_ld/reg_inc/reg_clr : one-hot destination register strobes
// Modports: master = requesters + register bank, slave = controller.
interface bus_xfer_ctrl_if
  import bus_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int N_REG = DEF_N_REG,
  parameter int SW    = DEF_SW
);
  logic [N_REQ-1:0]    req;
  logic [2*N_REQ-1:0]  op;
  logic [SW*N_REQ-1:0] src;
  logic [SW*N_REQ-1:0] dst;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                err;
  logic                busy;
  logic [SW-1:0]       bus_sel;
  logic [N_REG-1:0]    reg_ld;
  logic [N_REG-1:0]    reg_inc;
  logic [N_REG-1:0]    reg_clr;

  modport master (
    output req, op, src, dst,
    input  gnt, done, err, busy, bus_sel, reg_ld, reg_inc, reg_clr
  );

  modport slave (
    input  req, op, src, dst,
    output gnt, done, err, busy, bus_sel, reg_ld, reg_inc, reg_clr
  );
endinterface

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: combinational winner select.
//   req    : request vector to arbitrate
//   ptr    : index holding highest priority (round-robin)
//   any    : at least one request present
//   onehot : one-hot winner
//   idx    : winner index
// With BUS_XFER_FIXED_PRI_EN defined this is a lowest-index priority
// encoder and ptr is ignored.
module bus_rr_pick
  import bus_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             any,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx
);

`ifdef BUS_XFER_FIXED_PRI_EN
  // Scan from the top down so the lowest pending index is the last write.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] cand;

  // Walk the requesters starting at ptr, wrapping; first pending one wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end
`endif

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign onehot[gi] = any && (idx == PW'(gi));
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequencer/arbiter for the shared common bus.
//   clk : clock, all state changes on the rising edge
//   clr : synchronous active-high reset
//   bus : bus_xfer_ctrl_if slave modport (requests in; grant, done, err,
//         busy, bus source select and register strobes out)
// One transaction takes three cycles: SEL (grant, bus_sel settles),
// XFER (one strobe), ACK (done/err). Every output is decoded from
// registered state only.
// Build option: define BUS_XFER_FIXED_PRI_EN for fixed lowest-index
// priority (no round-robin pointer); default is round-robin.
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int N_REG = DEF_N_REG,
  parameter int SW    = DEF_SW
) (
  input logic             clk,
  input logic             clr,
  bus_xfer_ctrl_if.slave  bus
);

  localparam int PW = idx_w(N_REQ);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] win_oh_q, win_oh_d;
  logic [1:0]       op_q, op_d;
  logic [SW-1:0]    src_q, src_d;
  logic [SW-1:0]    dst_q, dst_d;
  logic             ill_q, ill_d;
  logic [PW-1:0]    ptr_q;

  logic [N_REQ-1:0] pick_req;
  logic             pick_any;
  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic [1:0]       op_sel;
  logic [SW-1:0]    src_sel, dst_sel;
  logic             ill_sel;
  logic             take;

  // In ACK the current winner's req is still its old request (it only sees
  // done this cycle), so it is excluded; if it is held it is picked up again
  // from IDLE. Under fixed priority a held req simply wins again.
  always_comb begin
    pick_req = bus.req;
`ifndef BUS_XFER_FIXED_PRI_EN
    if (state_q == ST_ACK) pick_req = bus.req & ~win_oh_q;
`endif
  end

  bus_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (pick_req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // Fields of the candidate winner, muxed by its one-hot.
  always_comb begin
    op_sel  = OP_XFER;
    src_sel = '0;
    dst_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        op_sel  = bus.op[2*i +: 2];
        src_sel = bus.src[SW*i +: SW];
        dst_sel = bus.dst[SW*i +: SW];
      end
    end
    ill_sel = (op_sel == OP_RSVD) ||
              (int'(dst_sel) >= N_REG) ||
              ((op_sel == OP_XFER) && (int'(src_sel) >= N_REG));
  end

  always_comb begin
    state_d  = state_q;
    win_oh_d = win_oh_q;
    op_d     = op_q;
    src_d    = src_q;
    dst_d    = dst_q;
    ill_d    = ill_q;
    take     = 1'b0;
    case (state_q)
      ST_IDLE: take = pick_any;
      ST_SEL:  state_d = ST_XFER;
      ST_XFER: state_d = ST_ACK;
      ST_ACK: begin
        take = pick_any;
        if (!pick_any) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Fields are captured only at the grant; later changes are ignored.
    if (take) begin
      state_d  = ST_SEL;
      win_oh_d = pick_oh;
      op_d     = op_sel;
      src_d    = src_sel;
      dst_d    = dst_sel;
      ill_d    = ill_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      win_oh_q <= '0;
      op_q     <= OP_XFER;
      src_q    <= '0;
      dst_q    <= '0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_oh_q <= win_oh_d;
      op_q     <= op_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      ill_q    <= ill_d;
    end
  end

`ifdef BUS_XFER_FIXED_PRI_EN
  assign ptr_q = '0;
`else
  logic [PW-1:0] ptr_d;

  // After a grant to w, w+1 (mod N_REQ) becomes highest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (take) ptr_d = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Handshake and bus select, decoded from registered state.
  always_comb begin
    bus.gnt     = '0;
    bus.done    = '0;
    bus.err     = 1'b0;
    bus.busy    = (state_q != ST_IDLE);
    bus.bus_sel = '0;
    if (state_q != ST_IDLE) begin
      bus.gnt = win_oh_q;
      if (op_q == OP_XFER) bus.bus_sel = src_q;
    end
    if (state_q == ST_ACK) begin
      bus.done = win_oh_q;
      bus.err  = ill_q;
    end
  end

  // Exactly one strobe in XFER for a legal request, none otherwise.
  logic fire;
  assign fire = (state_q == ST_XFER) && !ill_q;

  for (genvar gi = 0; gi < N_REG; gi++) begin : g_strobe
    logic hit;
    assign hit             = fire && (dst_q == SW'(gi));
    assign bus.reg_ld[gi]  = hit && (op_q == OP_XFER);
    assign bus.reg_inc[gi] = hit && (op_q == OP_INC);
    assign bus.reg_clr[gi] = hit && (op_q == OP_CLR);
  end

endmodule
